// File: rtl/int_gen_pkg.sv
// Shared definitions for the interrupt generator and the bridge address map.
// Holds register addresses, FSM encodings, CTRL bit positions and pending width.
// Pure declarations; no logic, so no latency or backpressure.
package int_gen_pkg;

  // Bridge address map (peripheral windows behind the CPU bridge)
  localparam logic [31:0] TIMER0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] INT_GEN_BASE = 32'h0000_7F20;

  // Interrupt generator registers
  localparam logic [31:0] IG_ACK_ADDR    = 32'h0000_7F20;
  localparam logic [31:0] IG_PERIOD_ADDR = 32'h0000_7F24;
  localparam logic [31:0] IG_CTRL_ADDR   = 32'h0000_7F28;
  localparam logic [31:0] IG_STATUS_ADDR = 32'h0000_7F2C;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;

  // Pending expiry counter
  localparam int                PEND_W   = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_ASSERT = 2'd2,
    S_GAP    = 2'd3
  } state_e;

  // Word index used for register decode (byte offset bits ignored)
  function automatic logic [29:0] word_addr(input logic [31:0] a);
    return a[31:2];
  endfunction

endpackage

// File: rtl/int_gen.sv
// Periodic / one-shot level interrupt generator with ACK, PERIOD, CTRL, STATUS regs.
// Latency: interrupt is registered; rises exactly PERIOD edges after the enabling write.
// No backpressure: writes always accepted in one cycle. INT_GEN_PENDING_EN enables pending expiry queueing.
module int_gen
  import int_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        interrupt
);

`ifdef INT_GEN_PENDING_EN
  localparam bit PendEn = 1'b1;
`else
  localparam bit PendEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [31:0]       period_q, period_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [PEND_W-1:0] pend_now;
  logic              interrupt_q;

  logic        wr_en;
  logic        sel_ack, sel_period, sel_ctrl, sel_status;
  logic        wr_ack, wr_period, wr_ctrl;
  logic [31:0] reload;
  logic [PEND_W-1:0] pend_rd;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr[1:0];

  assign wr_en      = |byteen;
  assign sel_ack    = (word_addr(addr) == word_addr(IG_ACK_ADDR));
  assign sel_period = (word_addr(addr) == word_addr(IG_PERIOD_ADDR));
  assign sel_ctrl   = (word_addr(addr) == word_addr(IG_CTRL_ADDR));
  assign sel_status = (word_addr(addr) == word_addr(IG_STATUS_ADDR));

  assign wr_ack    = wr_en && sel_ack;
  assign wr_period = wr_en && sel_period;
  assign wr_ctrl   = wr_en && sel_ctrl;

  // A zero period behaves as a one-edge period
  assign reload  = (period_q == 32'd0) ? 32'd1 : period_q;
  assign pend_rd = PendEn ? pending_q : '0;

  // Next-state logic: a CTRL write overrides every other event in the same cycle
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    pend_now  = pending_q;

    // New period only takes effect at the next reload
    if (wr_period) period_d = wdata;

    if (wr_ctrl) begin
      ctrl_d    = wdata[1:0];
      pending_d = '0;
      if (wdata[CTRL_EN]) begin
        state_d = S_COUNT;
        cnt_d   = reload;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_COUNT: begin
          if (cnt_q == 32'd1) begin
            state_d = S_ASSERT;
            // Keep timing in ASSERT only when expiries are being queued
            cnt_d   = (PendEn && ctrl_q[CTRL_AUTO]) ? reload : cnt_q;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_ASSERT: begin
          // An expiry on the ACK edge is counted before the ACK consumes one
          if (PendEn && ctrl_q[CTRL_AUTO]) begin
            if (cnt_q == 32'd1) begin
              cnt_d = reload;
              if (pending_q != PEND_MAX) pend_now = pending_q + PEND_W'(1);
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
          pending_d = pend_now;
          if (wr_ack) begin
            if (pend_now != '0) begin
              pending_d = pend_now - PEND_W'(1);
              state_d   = S_GAP;
            end else if (ctrl_q[CTRL_AUTO]) begin
              state_d = S_COUNT;
              cnt_d   = reload;
            end else begin
              state_d         = S_IDLE;
              cnt_d           = '0;
              ctrl_d[CTRL_EN] = 1'b0;
            end
          end
        end
        // One deasserted cycle between back-to-back queued interrupts; cnt holds
        S_GAP: state_d = S_ASSERT;
      endcase
    end
  end

  // State registers with synchronous active-low reset; bus writes dropped under reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      pending_q   <= '0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      pending_q   <= pending_d;
      interrupt_q <= (state_d == S_ASSERT);
    end
  end

  // Combinational register read; ACK and unmapped addresses read as zero
  always_comb begin
    rdata = '0;
    if (sel_period)      rdata = period_q;
    else if (sel_ctrl)   rdata = {30'b0, ctrl_q};
    else if (sel_status) rdata = {25'b0, state_q, interrupt_q, pend_rd};
  end

  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_int_gen.sv
// Bench for int_gen: reference model predicts rdata/interrupt per cycle into a queue,
// a monitor pops and compares on the falling edge; directed scenarios add timing checks.
// Define INT_GEN_PENDING_EN for both DUT and bench to exercise pending queueing.
module tb_int_gen;

`ifdef INT_GEN_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  localparam logic [31:0] A_ACK    = 32'h0000_7F20;
  localparam logic [31:0] A_PERIOD = 32'h0000_7F24;
  localparam logic [31:0] A_CTRL   = 32'h0000_7F28;
  localparam logic [31:0] A_STATUS = 32'h0000_7F2C;

  localparam int ST_IDLE = 0, ST_COUNT = 1, ST_ASSERT = 2, ST_GAP = 3;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  int_gen dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .byteen    (byteen),
    .wdata     (wdata),
    .rdata     (rdata),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        intr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int          m_state;
  logic [31:0] m_period;
  logic [31:0] m_cnt;
  int          m_pend;
  bit          m_en, m_auto;

  logic [31:0] addr_pool [7] = '{32'h0000_7F20, 32'h0000_7F24, 32'h0000_7F28, 32'h0000_7F2C,
                                 32'h0000_7F30, 32'h0000_7F26, 32'h0001_7F24};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got 0x%08h want 0x%08h", nm, $time, act, exp);
    end
  endtask

  function automatic bit is_reg(input logic [31:0] a, input logic [31:0] r);
    return {a[31:2], 2'b00} == r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] st;
    st = m_state * 32 + ((m_state == ST_ASSERT) ? 16 : 0) + m_pend;
    if (is_reg(a, A_PERIOD)) return m_period;
    if (is_reg(a, A_CTRL))   return {30'b0, m_auto, m_en};
    if (is_reg(a, A_STATUS)) return st;
    return 32'd0;
  endfunction

  // One clock edge of the behavioural model
  task automatic m_step(input logic r, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
    logic [31:0] eff;
    bit wr;
    if (!r) begin
      m_state = ST_IDLE; m_period = 0; m_cnt = 0; m_pend = 0; m_en = 0; m_auto = 0;
      return;
    end
    wr  = (be != 4'b0);
    eff = (m_period == 0) ? 32'd1 : m_period;
    if (wr && is_reg(a, A_CTRL)) begin
      m_en = wd[0]; m_auto = wd[1]; m_pend = 0;
      m_state = wd[0] ? ST_COUNT : ST_IDLE;
      m_cnt   = wd[0] ? eff : 32'd0;
    end else if (m_state == ST_COUNT) begin
      if (m_cnt == 1) begin
        m_state = ST_ASSERT;
        if (PEND && m_auto) m_cnt = eff;
      end else m_cnt = m_cnt - 1;
    end else if (m_state == ST_GAP) begin
      m_state = ST_ASSERT;
    end else if (m_state == ST_ASSERT) begin
      if (PEND && m_auto) begin
        if (m_cnt == 1) begin
          m_cnt = eff;
          if (m_pend < 15) m_pend++;
        end else m_cnt = m_cnt - 1;
      end
      if (wr && is_reg(a, A_ACK)) begin
        if (m_pend > 0) begin m_pend--; m_state = ST_GAP; end
        else if (m_auto) begin m_state = ST_COUNT; m_cnt = eff; end
        else begin m_state = ST_IDLE; m_cnt = 0; m_en = 0; end
      end
    end
    if (wr && is_reg(a, A_PERIOD)) m_period = wd;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the predicted entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_interrupt", {31'b0, interrupt}, {31'b0, e.intr});
        check("sb_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic drive(input logic r, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    exp_t e;
    reset = r; addr = a; byteen = be; wdata = wd;
    e.rdata = m_read(a);
    e.intr  = (m_state == ST_ASSERT);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(reset, addr, byteen, wdata);
    #1;
  endtask

  task automatic cyc(input logic r, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd);
    drive(r, a, be, wd);
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, 4'hF, d);
  endtask

  task automatic idle1();
    cyc(1'b1, addr_pool[$urandom_range(0, 6)], 4'b0, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) idle1();
  endtask

  task automatic expect_reg(input string nm, input logic [31:0] a, input logic [31:0] v);
    drive(1'b1, a, 4'b0, $urandom);
    #1;
    check(nm, rdata, v);
    tick();
  endtask

  // Count edges until interrupt is seen high, bounded by limit
  task automatic wait_rise(input int limit, output int n);
    n = 0;
    while (interrupt !== 1'b1 && n < limit) begin
      idle1();
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; addr = '0; byteen = '0; wdata = '0;
    @(posedge clk);
    m_step(1'b0, 32'd0, 4'd0, 32'd0);
    #1;

    // Reset state
    check("reset_interrupt", {31'b0, interrupt}, 32'd0);
    expect_reg("reset_status", A_STATUS, 32'd0);
    expect_reg("reset_period", A_PERIOD, 32'd0);
    expect_reg("reset_ctrl", A_CTRL, 32'd0);

    // One-shot: PERIOD=5
    wr(A_PERIOD, 32'd5);
    wr(A_CTRL, 32'h1);
    wait_rise(50, n);
    check("oneshot_rise_edges", n, 32'd5);
    expect_reg("oneshot_status_assert", A_STATUS, 32'h50);
    cyc(1'b1, A_ACK, 4'b0001, $urandom);
    check("oneshot_ack_low", {31'b0, interrupt}, 32'd0);
    expect_reg("oneshot_status_idle", A_STATUS, 32'h00);
    expect_reg("oneshot_en_cleared", A_CTRL, 32'h0);

    // Auto mode: PERIOD=3, ACK two edges after each rise
    wr(A_PERIOD, 32'd3);
    wr(A_CTRL, 32'h3);
    for (int k = 0; k < 3; k++) begin
      wait_rise(50, n);
      check("auto_rise_edges", n, 32'd3);
      if (k < 2) begin
        idle1();
        cyc(1'b1, A_ACK, 4'b0100, $urandom);
      end
    end
    // Disable while asserted
    wr(A_CTRL, 32'h0);
    check("disable_intr", {31'b0, interrupt}, 32'd0);
    expect_reg("disable_status", A_STATUS, 32'h0);

`ifdef INT_GEN_PENDING_EN
    // Pending: PERIOD=2, ACK withheld 7 cycles after the rise
    wr(A_PERIOD, 32'd2);
    wr(A_CTRL, 32'h3);
    wait_rise(50, n);
    check("pend_rise_edges", n, 32'd2);
    idle(6);
    addr = A_STATUS; byteen = 4'b0;
    #1;
    check("pend_status_3", rdata, 32'h53);
    cyc(1'b1, A_ACK, 4'b0001, $urandom);
    check("pend_gap_low", {31'b0, interrupt}, 32'd0);
    expect_reg("pend_gap_status", A_STATUS, 32'h62);
    check("pend_reassert", {31'b0, interrupt}, 32'd1);
    expect_reg("pend_reassert_status", A_STATUS, 32'h52);
    wr(A_CTRL, 32'h0);
    expect_reg("pend_disable_status", A_STATUS, 32'h0);
`endif

    // Reset mid-COUNT; the write in the reset cycle is dropped
    wr(A_PERIOD, 32'd100);
    wr(A_CTRL, 32'h1);
    idle(39);
    cyc(1'b0, A_PERIOD, 4'hF, 32'h1234_5678);
    check("rst_intr", {31'b0, interrupt}, 32'd0);
    expect_reg("rst_period", A_PERIOD, 32'd0);
    expect_reg("rst_ctrl", A_CTRL, 32'd0);
    expect_reg("rst_status", A_STATUS, 32'd0);
    wait_rise(200, n);
    check("rst_no_intr_200", n, 32'd200);

    // PERIOD=0 behaves as 1; ACK in IDLE is ignored
    wr(A_PERIOD, 32'd0);
    wr(A_CTRL, 32'h1);
    wait_rise(20, n);
    check("p0_rise_edges", n, 32'd1);
    cyc(1'b1, A_ACK, 4'b1000, $urandom);
    cyc(1'b1, A_ACK, 4'b0001, $urandom);
    expect_reg("idle_ack_status", A_STATUS, 32'd0);
    check("idle_ack_intr", {31'b0, interrupt}, 32'd0);

    // Randomised traffic checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      int unsigned k;
      logic [3:0] be;
      k  = $urandom_range(0, 99);
      be = 4'($urandom_range(1, 15));
      if (k < 45)      idle1();
      else if (k < 55) wr(A_PERIOD, $urandom_range(0, 6));
      else if (k < 63) wr(A_CTRL, $urandom_range(0, 3));
      else if (k < 85) cyc(1'b1, A_ACK, be, $urandom);
      else if (k < 92) cyc(1'b1, addr_pool[$urandom_range(3, 6)], be, $urandom);
      else if (k < 94) cyc(1'b0, addr_pool[$urandom_range(0, 6)], be, $urandom);
      else             cyc(1'b1, A_CTRL, 4'b0, $urandom);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_gen.md
INT_GEN -- requirements
Module: int_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port addr, input, 32 bits: bus address from bridge/CPU (m_int_addr side); decode uses addr[31:2] only.
REQ-004 SHALL have port byteen, input, 4 bits: write strobe; any nonzero value is a write to the decoded register.
REQ-005 SHALL have port wdata, input, 32 bits: write data.
REQ-006 SHALL have port rdata, output, 32 bits: combinational read of the decoded register; 0 for unmapped addresses.
REQ-007 SHALL have port interrupt, output, 1 bit: level interrupt request to the CPU HWInt[2].

Function
REQ-008 SHALL decode registers: 0x7F20 ACK (write-only, reads 0), 0x7F24 PERIOD[31:0], 0x7F28 CTRL (bit0 EN, bit1 AUTO), 0x7F2C STATUS (read-only).
REQ-009 SHALL read STATUS as {25'b0, state[1:0] at bits 6:5, interrupt at bit 4, pending[3:0] at bits 3:0}.
REQ-010 SHALL implement FSM states IDLE=0, COUNT=1, ASSERT=2, GAP=3; interrupt=1 only in ASSERT (registered, no combinational path from inputs).
REQ-011 SHALL on a CTRL write with EN=1 enter COUNT and load cnt=PERIOD (PERIOD=0 treated as 1), using the PERIOD value registered before that edge.
REQ-012 SHALL in COUNT decrement cnt each edge; the edge seeing cnt==1 enters ASSERT, so interrupt rises exactly PERIOD edges after the enabling write edge.
REQ-013 SHALL leave ASSERT on the edge of an ACK write: AUTO=1 -> COUNT with cnt reloaded; AUTO=0 -> IDLE with CTRL.EN cleared.
REQ-014 SHALL give a CTRL write with EN=0 priority over every other event: next state IDLE, cnt=0, pending=0, interrupt=0.
REQ-015 SHALL apply PERIOD writes during COUNT/ASSERT only at the next reload; the running cnt is unaffected.
REQ-016 SHALL ignore ACK writes outside ASSERT, and writes to STATUS or unmapped addresses.
REQ-017 SHALL keep cnt at 32 bits with no wrap: it never decrements below 1.

Reset
REQ-018 SHALL on reset=0 at an edge set state=IDLE, CTRL=0, PERIOD=0, cnt=0, pending=0, interrupt=0, including mid-COUNT or mid-ASSERT; bus writes in that cycle are dropped.

Configuration
REQ-019 SHALL with INT_GEN_PENDING_EN defined keep cnt running in ASSERT when AUTO=1, with each expiry incrementing pending (saturating at 15). On ACK with pending>0 it SHALL go to GAP (interrupt=0 one cycle), decrement pending, then return to ASSERT. Expiry and ACK on the same edge SHALL count the expiry into pending first.
REQ-020 SHALL without INT_GEN_PENDING_EN freeze cnt in ASSERT, never enter GAP, and read pending as 0.

Structure
REQ-021 SHALL place register addresses (0x7F20..0x7F2C), FSM state encodings, the CTRL bit indices and the pending width (4) in the shared package alongside the bridge address map.
REQ-022 SHALL be a single module; no sub-module is needed.

Verification
REQ-023 SHALL cover one-shot: PERIOD=5, CTRL=0x1 -> interrupt rises 5 edges after the CTRL write; ACK at 0x7F20 with byteen=4'b0001 -> interrupt low next edge, STATUS=0x00.
REQ-024 SHALL cover auto mode: PERIOD=3, CTRL=0x3, ACK 2 cycles after each rise -> interrupt rises again 3 edges after each ACK edge.
REQ-025 SHALL cover pending (macro defined): PERIOD=2, CTRL=0x3, ACK withheld 7 cycles -> STATUS[3:0]=3. The ACK SHALL produce one low cycle (GAP) and then re-assertion with pending=2.
REQ-026 SHALL cover disable priority: in ASSERT, ACK and CTRL=0x0 on the same cycle -> IDLE, interrupt=0, pending=0.
REQ-027 SHALL cover reset mid-COUNT: PERIOD=100, enable, reset=0 at cycle 40 -> all outputs 0, no interrupt within 200 cycles.
REQ-028 SHALL cover PERIOD=0 with enable -> interrupt 1 edge later; an ACK while IDLE causes no state change.
